// File: rtl/level_sequencer.sv
// Game-flow sequencer: loads levels, arms/releases birds, counts pig hits and
// birds used, and decides level clear, advance, game over and game won.
module level_sequencer #(
    parameter int NUM_LEVELS      = 3,
    parameter int BIRDS_PER_LEVEL = 3,
    parameter int SETTLE_FRAMES   = 30,
    parameter int CLEAR_FRAMES    = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       start_key,
    input  logic       launch_key,
    input  logic       pig_hit,
    input  logic       bird_done,
    input  logic [3:0] level_pig_count,
    output logic [3:0] current_level,
    output logic [3:0] birds_left,
    output logic [3:0] pigs_left,
    output logic       load_level,
    output logic       bird_armed,
    output logic       bird_release,
    output logic       level_done,
    output logic       game_over,
    output logic       game_won
);

    localparam int MAX_FRAMES = (SETTLE_FRAMES > CLEAR_FRAMES) ? SETTLE_FRAMES : CLEAR_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        AIM    = 3'd2,
        FLIGHT = 3'd3,
        SETTLE = 3'd4,
        CLEAR  = 3'd5,
        OVER   = 3'd6,
        WON    = 3'd7
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic             start_d_r;
    logic             launch_d_r;
    logic [CNT_W-1:0] frame_cnt_r;

    logic             start_rise_s;
    logic             launch_rise_s;
    logic             pig_count_s;
    logic [3:0]       pigs_after_s;
    logic             settle_end_s;
    logic             clear_end_s;

    logic [3:0]       level_s;
    logic [3:0]       birds_s;
    logic [3:0]       pigs_s;
    logic             release_s;

    assign start_rise_s  = start_key & ~start_d_r;
    assign launch_rise_s = launch_key & ~launch_d_r;
    assign pig_count_s   = pig_hit & ((state_r == FLIGHT) | (state_r == SETTLE));
    // A hit landing on the judging frame still counts toward the verdict.
    assign pigs_after_s  = (pig_count_s && (pigs_left != 4'd0)) ? (pigs_left - 4'd1) : pigs_left;
    assign settle_end_s  = (state_r == SETTLE) & startOfFrame & (frame_cnt_r == CNT_W'(SETTLE_FRAMES - 1));
    assign clear_end_s   = (state_r == CLEAR) & startOfFrame & (frame_cnt_r == CNT_W'(CLEAR_FRAMES - 1));

    // State register, key edge history and frame counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r     <= IDLE;
            start_d_r   <= 1'b0;
            launch_d_r  <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            state_r    <= state_next_s;
            start_d_r  <= start_key;
            launch_d_r <= launch_key;
            if (state_next_s != state_r) begin
                frame_cnt_r <= '0;
            end else if (startOfFrame && ((state_r == SETTLE) || (state_r == CLEAR))) begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Next-state decision.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = start_rise_s ? LOAD : IDLE;
            LOAD:    state_next_s = AIM;
            AIM: begin
                if (start_rise_s)       state_next_s = LOAD;
                else if (launch_rise_s) state_next_s = FLIGHT;
                else                    state_next_s = AIM;
            end
            FLIGHT: begin
                if (start_rise_s)   state_next_s = LOAD;
                else if (bird_done) state_next_s = SETTLE;
                else                state_next_s = FLIGHT;
            end
            SETTLE: begin
                if (start_rise_s) begin
                    state_next_s = LOAD;
                end else if (settle_end_s) begin
                    if (pigs_after_s == 4'd0)     state_next_s = CLEAR;
                    else if (birds_left != 4'd0)  state_next_s = AIM;
                    else                          state_next_s = OVER;
                end else begin
                    state_next_s = SETTLE;
                end
            end
            CLEAR: begin
                if (!clear_end_s)                               state_next_s = CLEAR;
                else if (current_level == 4'(NUM_LEVELS - 1))  state_next_s = WON;
                else                                            state_next_s = LOAD;
            end
            OVER:    state_next_s = start_rise_s ? LOAD : OVER;
            WON:     state_next_s = start_rise_s ? LOAD : WON;
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        level_s   = current_level;
        birds_s   = birds_left;
        pigs_s    = pigs_left;
        release_s = (state_r == AIM) && (state_next_s == FLIGHT);
        if (state_next_s == LOAD) begin
            if (state_r == CLEAR)
                level_s = current_level + 4'd1;
            else if ((state_r == IDLE) || (state_r == OVER) || (state_r == WON))
                level_s = 4'd0;
            else
                level_s = current_level;
        end else begin
            level_s = current_level;
        end
        if (state_r == LOAD) begin
            birds_s = 4'(BIRDS_PER_LEVEL);
            pigs_s  = (level_pig_count == 4'd0) ? 4'd1 : level_pig_count;
        end else if (release_s) begin
            birds_s = birds_left - 4'd1;
            pigs_s  = pigs_left;
        end else begin
            birds_s = birds_left;
            pigs_s  = pigs_after_s;
        end
    end

    // Output registers; flags decode the state being entered.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            current_level <= 4'd0;
            birds_left    <= 4'd0;
            pigs_left     <= 4'd0;
            load_level    <= 1'b0;
            bird_armed    <= 1'b0;
            bird_release  <= 1'b0;
            level_done    <= 1'b0;
            game_over     <= 1'b0;
            game_won      <= 1'b0;
        end else begin
            current_level <= level_s;
            birds_left    <= birds_s;
            pigs_left     <= pigs_s;
            load_level    <= (state_next_s == LOAD);
            bird_armed    <= (state_next_s == AIM);
            bird_release  <= release_s;
            level_done    <= (state_next_s == CLEAR);
            game_over     <= (state_next_s == OVER);
            game_won      <= (state_next_s == WON);
        end
    end

endmodule
